elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
- Collects floor calls from cab/hall buttons into a pending-request bitmap.
- Issues one target floor at a time to the elevator car FSM using LOOK ordering: keeps sweeping in the current direction while calls remain ahead of the car, then reverses.
- Sits between the button/decoder logic and the car FSM.
- Replaces the plain call FIFO so that calls are served in sweep order rather than arrival order.

Parameters:
NUM_FLOORS, 16, number of serviced floors (2..16); floors are 0..NUM_FLOORS-1
FLOOR_W, 4, floor-number width; must satisfy 2**FLOOR_W >= NUM_FLOORS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
call_valid  input  1  one-cycle call strobe; at most one call per cycle
call_floor  input  FLOOR_W  requested floor, sampled when call_valid=1
cur_floor  input  FLOOR_W  car's current floor, from the car FSM
car_door  input  1  car FSM arrival pulse (door open for one cycle)
tgt_ready  input  1  car FSM accepts the target
tgt_valid  output  1  target offered to the car FSM
tgt_floor  output  FLOOR_W  offered target floor
door_req  output  1  one-cycle pulse: reopen the door at the current floor
call_err  output  1  one-cycle pulse: out-of-range call dropped
pending  output  NUM_FLOORS  pending-request bitmap, bit i = floor i
sweep_up  output  1  1 = sweeping up, 0 = sweeping down

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, pending=0, sweep_up=1.
  - tgt_valid=0, tgt_floor=0, door_req=0, call_err=0.
  - Internal inflight register = 0.
  - Reset mid-operation discards all pending and in-flight requests.
- Call capture:
  - When call_valid=1 and call_floor<NUM_FLOORS, pending[call_floor] is set on the next edge.
  - Duplicate calls are idempotent.
  - When call_floor>=NUM_FLOORS, the call is dropped and call_err pulses on the next cycle.
- Clear:
  - In WAIT, car_door=1 with cur_floor==inflight clears pending[inflight].
  - If a call to the same floor arrives in the same cycle as its clear, the clear wins and the bit ends at 0.
  - A call to any other floor in that cycle is still captured.
- State machine (IDLE, ISSUE, WAIT):
  - IDLE, pending[cur_floor]=1:
    - Clear that bit and pulse door_req the next cycle.
    - Stay in IDLE; no target is issued for this bit.
  - IDLE, pending=0: stay in IDLE.
  - IDLE, other pending bits set: run the selection rules below, latch the result into inflight and tgt_floor, go to ISSUE.
  - Selection with sweep_up=1:
    - If any pending floor is above cur_floor, take the lowest such floor.
    - Otherwise take the highest pending floor below cur_floor and set sweep_up=0.
  - Selection with sweep_up=0: mirror image of the above; take the highest floor below, else the lowest floor above and set sweep_up=1.
  - ISSUE:
    - tgt_valid=1; tgt_floor is held stable.
    - On tgt_valid&tgt_ready go to WAIT; tgt_valid=0 from the next cycle.
  - WAIT:
    - Wait for car_door=1 with cur_floor==inflight, then clear the bit and go to IDLE.
    - car_door at any other floor is ignored.
    - New calls accumulate but are never issued; exactly one target is outstanding at a time.
- Latency:
  - From call_valid (cycle N) with an idle scheduler: pending set at N+1, tgt_valid at N+2.
  - From arrival pulse to the next tgt_valid: 2 cycles.
- Selection is purely combinational over pending and cur_floor and is registered on entry to ISSUE.
- Boundaries:
  - Floor 0 and floor NUM_FLOORS-1 are handled with no wrap-around.
  - pending bits at or above NUM_FLOORS are never set.

Test Plan:
- Reset, cur_floor=0, call 5 at cycle 0 -> pending=0x0020 at cycle 1; tgt_valid=1, tgt_floor=5 at cycle 2; held until tgt_ready.
- cur_floor=4, sweep_up=1, pending {2,6,9} -> targets issued 6, 9, then 2 (sweep_up flips to 0 on selecting 2); each target issued only after a matching car_door.
- In WAIT with inflight=7: call 7 in the same cycle as car_door at cur_floor=7 -> pending[7]=0 afterwards; a call to 3 in that cycle is captured, bit 3=1.
- IDLE at cur_floor=3, call 3 -> door_req pulses once, pending returns to 0, tgt_valid stays 0.
- NUM_FLOORS=10, call 12 -> call_err pulses one cycle, pending unchanged; duplicate calls to 4 (3 strobes) -> exactly one target 4 issued.
- Assert rst while in ISSUE with pending {1,8} -> tgt_valid=0 and pending=0 immediately, sweep_up=1; normal operation after release.

Source files
------------

// File: rtl/elevator_call_scheduler_if.sv
// rtl/elevator_call_scheduler_if.sv - call/target/status bundle between button logic, scheduler and car FSM
//
// Signals:
//   call_valid/call_floor  : one-cycle call strobe and requested floor
//   cur_floor/car_door     : car position and one-cycle arrival pulse
//   tgt_valid/tgt_ready    : target handshake toward the car FSM
//   tgt_floor              : offered target floor
//   door_req/call_err      : one-cycle status pulses
//   pending/sweep_up       : request bitmap and current sweep direction
// Modports: slave = scheduler side, master = button/car side.
interface elevator_call_scheduler_if #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
);
    logic                  call_valid;
    logic [FLOOR_W-1:0]    call_floor;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  car_door;
    logic                  tgt_ready;
    logic                  tgt_valid;
    logic [FLOOR_W-1:0]    tgt_floor;
    logic                  door_req;
    logic                  call_err;
    logic [NUM_FLOORS-1:0] pending;
    logic                  sweep_up;

    modport slave (
        input  call_valid, call_floor, cur_floor, car_door, tgt_ready,
        output tgt_valid, tgt_floor, door_req, call_err, pending, sweep_up
    );

    modport master (
        output call_valid, call_floor, cur_floor, car_door, tgt_ready,
        input  tgt_valid, tgt_floor, door_req, call_err, pending, sweep_up
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - LOOK-order floor call scheduler feeding the car FSM one target at a time
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : elevator_call_scheduler_if.slave (calls in, car status in,
//          target handshake out, door_req/call_err pulses, pending bitmap, sweep direction)
module elevator_call_scheduler #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    elevator_call_scheduler_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  sweep_up_q, sweep_up_d;
    logic [FLOOR_W-1:0]    tgt_floor_q, tgt_floor_d;
    logic [FLOOR_W-1:0]    inflight_q, inflight_d;
    logic                  door_req_q, door_req_d;
    logic                  call_err_q, call_err_d;

    logic                  call_ok;
    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic                  at_cur;
    logic                  above_any, below_any;
    logic [FLOOR_W-1:0]    above_sel, below_sel;
    logic                  arrived;

    // Extra bit so NUM_FLOORS == 2**FLOOR_W compares correctly.
    assign call_ok = bus.call_valid &&
                     ({1'b0, bus.call_floor} < (FLOOR_W+1)'(NUM_FLOORS));
    assign arrived = (state_q == ST_WAIT) && bus.car_door &&
                     (bus.cur_floor == inflight_q);

    // Nearest pending floor above and below the car. The descending scan
    // leaves the lowest floor above; the ascending scan the highest below.
    always_comb begin
        at_cur    = 1'b0;
        above_any = 1'b0;
        below_any = 1'b0;
        above_sel = '0;
        below_sel = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (FLOOR_W'(i) > bus.cur_floor)) begin
                above_any = 1'b1;
                above_sel = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (FLOOR_W'(i) < bus.cur_floor)) begin
                below_any = 1'b1;
                below_sel = FLOOR_W'(i);
            end
            if (pending_q[i] && (FLOOR_W'(i) == bus.cur_floor)) begin
                at_cur = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_up_d  = sweep_up_q;
        tgt_floor_d = tgt_floor_q;
        inflight_d  = inflight_q;
        door_req_d  = 1'b0;
        call_err_d  = bus.call_valid && !call_ok;
        set_mask    = '0;
        clr_mask    = '0;

        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (call_ok && (bus.call_floor == FLOOR_W'(i))) begin
                set_mask[i] = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (at_cur) begin
                    // Car is already here: reopen the door instead of issuing.
                    for (int i = 0; i < NUM_FLOORS; i++) begin
                        if (bus.cur_floor == FLOOR_W'(i)) begin
                            clr_mask[i] = 1'b1;
                        end
                    end
                    door_req_d = 1'b1;
                end else if (pending_q != '0) begin
                    if (sweep_up_q) begin
                        if (above_any) begin
                            tgt_floor_d = above_sel;
                        end else begin
                            tgt_floor_d = below_sel;
                            sweep_up_d  = 1'b0;
                        end
                    end else begin
                        if (below_any) begin
                            tgt_floor_d = below_sel;
                        end else begin
                            tgt_floor_d = above_sel;
                            sweep_up_d  = 1'b1;
                        end
                    end
                    inflight_d = tgt_floor_d;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.tgt_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (arrived) begin
                    for (int i = 0; i < NUM_FLOORS; i++) begin
                        if (inflight_q == FLOOR_W'(i)) begin
                            clr_mask[i] = 1'b1;
                        end
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear is applied after set so a same-floor call in the clear cycle is absorbed.
        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            sweep_up_q  <= 1'b1;
            tgt_floor_q <= '0;
            inflight_q  <= '0;
            door_req_q  <= 1'b0;
            call_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            sweep_up_q  <= sweep_up_d;
            tgt_floor_q <= tgt_floor_d;
            inflight_q  <= inflight_d;
            door_req_q  <= door_req_d;
            call_err_q  <= call_err_d;
        end
    end

    assign bus.tgt_valid = (state_q == ST_ISSUE);
    assign bus.tgt_floor = tgt_floor_q;
    assign bus.door_req  = door_req_q;
    assign bus.call_err  = call_err_q;
    assign bus.pending   = pending_q;
    assign bus.sweep_up  = sweep_up_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - vector-table bench for elevator_call_scheduler with 10 floors
module tb_elevator_call_scheduler;

    localparam int NF = 10;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    elevator_call_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_call_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic          cv;
        logic [FW-1:0] cf;
        logic [FW-1:0] cur;
        logic          door;
        logic          rdy;
        logic          tv;
        logic [FW-1:0] tf;
        logic [NF-1:0] pend;
        logic          sw;
        logic          dr;
        logic          ce;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic cv, input int cf, input int cur, input logic door,
                       input logic rdy, input logic tv, input int tf, input int pend,
                       input logic sw, input logic dr, input logic ce);
        vec_t v;
        v.cv = cv; v.cf = FW'(cf); v.cur = FW'(cur); v.door = door; v.rdy = rdy;
        v.tv = tv; v.tf = FW'(tf); v.pend = NF'(pend); v.sw = sw; v.dr = dr; v.ce = ce;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input int cf, input int cur, input logic door,
                         input logic rdy);
        bus.call_valid = cv;
        bus.call_floor = FW'(cf);
        bus.cur_floor  = FW'(cur);
        bus.car_door   = door;
        bus.tgt_ready  = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 0, 0, 1'b0, 1'b0);

        //   cv cf cur dr rdy | tv tf pend    sw dr ce
        add(1, 5, 0, 0, 0,   0, 0, 'h020, 1, 0, 0);  // 0  call 5
        add(0, 0, 0, 0, 0,   1, 5, 'h020, 1, 0, 0);  // 1  offered at N+2
        add(0, 0, 0, 0, 0,   1, 5, 'h020, 1, 0, 0);  // 2  held without ready
        add(0, 0, 0, 0, 1,   0, 5, 'h020, 1, 0, 0);  // 3  accepted
        add(0, 0, 3, 1, 0,   0, 5, 'h020, 1, 0, 0);  // 4  door at wrong floor ignored
        add(0, 0, 5, 1, 0,   0, 5, 'h000, 1, 0, 0);  // 5  arrival clears 5
        add(1, 6, 4, 0, 0,   0, 5, 'h040, 1, 0, 0);  // 6  call 6
        add(1, 2, 4, 0, 0,   1, 6, 'h044, 1, 0, 0);  // 7  issue 6, call 2
        add(1, 9, 4, 0, 1,   0, 6, 'h244, 1, 0, 0);  // 8  accept, call 9
        add(0, 0, 6, 1, 0,   0, 6, 'h204, 1, 0, 0);  // 9  arrive 6
        add(0, 0, 6, 0, 0,   1, 9, 'h204, 1, 0, 0);  // 10 keep sweeping up: 9
        add(0, 0, 6, 0, 1,   0, 9, 'h204, 1, 0, 0);  // 11
        add(0, 0, 9, 1, 0,   0, 9, 'h004, 1, 0, 0);  // 12 arrive 9
        add(0, 0, 9, 0, 0,   1, 2, 'h004, 0, 0, 0);  // 13 reverse to 2
        add(0, 0, 9, 0, 1,   0, 2, 'h004, 0, 0, 0);  // 14
        add(1, 2, 2, 1, 0,   0, 2, 'h000, 0, 0, 0);  // 15 call 2 with its clear: clear wins
        add(0, 0, 2, 0, 0,   0, 2, 'h000, 0, 0, 0);  // 16 nothing issued
        add(1, 7, 2, 0, 0,   0, 2, 'h080, 0, 0, 0);  // 17 call 7
        add(0, 0, 2, 0, 0,   1, 7, 'h080, 1, 0, 0);  // 18 nothing below -> up to 7
        add(0, 0, 2, 0, 1,   0, 7, 'h080, 1, 0, 0);  // 19
        add(1, 3, 7, 1, 0,   0, 7, 'h008, 1, 0, 0);  // 20 arrive 7, call 3 captured
        add(0, 0, 7, 0, 0,   1, 3, 'h008, 0, 0, 0);  // 21 reverse to 3
        add(0, 0, 7, 0, 1,   0, 3, 'h008, 0, 0, 0);  // 22
        add(0, 0, 3, 1, 0,   0, 3, 'h000, 0, 0, 0);  // 23 arrive 3
        add(1, 3, 3, 0, 0,   0, 3, 'h008, 0, 0, 0);  // 24 call at current floor
        add(0, 0, 3, 0, 0,   0, 3, 'h000, 0, 1, 0);  // 25 door_req, no target
        add(0, 0, 3, 0, 0,   0, 3, 'h000, 0, 0, 0);  // 26 single pulse
        add(1, 12, 3, 0, 0,  0, 3, 'h000, 0, 0, 1);  // 27 out of range
        add(1, 10, 3, 0, 0,  0, 3, 'h000, 0, 0, 1);  // 28 first out-of-range floor
        add(0, 0, 3, 0, 0,   0, 3, 'h000, 0, 0, 0);  // 29 call_err drops
        add(1, 4, 3, 0, 0,   0, 3, 'h010, 0, 0, 0);  // 30 call 4 (1st)
        add(1, 4, 3, 0, 0,   1, 4, 'h010, 1, 0, 0);  // 31 call 4 (2nd), issue 4
        add(1, 4, 3, 0, 1,   0, 4, 'h010, 1, 0, 0);  // 32 call 4 (3rd), accept
        add(0, 0, 4, 1, 0,   0, 4, 'h000, 1, 0, 0);  // 33 arrive 4
        add(0, 0, 4, 0, 0,   0, 4, 'h000, 1, 0, 0);  // 34 no second target
        add(1, 9, 4, 0, 0,   0, 4, 'h200, 1, 0, 0);  // 35 top floor
        add(0, 0, 4, 0, 0,   1, 9, 'h200, 1, 0, 0);  // 36
        add(0, 0, 4, 0, 1,   0, 9, 'h200, 1, 0, 0);  // 37
        add(0, 0, 9, 1, 0,   0, 9, 'h000, 1, 0, 0);  // 38
        add(1, 0, 9, 0, 0,   0, 9, 'h001, 1, 0, 0);  // 39 bottom floor
        add(0, 0, 9, 0, 0,   1, 0, 'h001, 0, 0, 0);  // 40
        add(0, 0, 9, 0, 1,   0, 0, 'h001, 0, 0, 0);  // 41
        add(0, 0, 0, 1, 0,   0, 0, 'h000, 0, 0, 0);  // 42

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset tgt_valid", 32'(bus.tgt_valid), 0);
        chk("reset tgt_floor", 32'(bus.tgt_floor), 0);
        chk("reset pending",   32'(bus.pending),   0);
        chk("reset sweep_up",  32'(bus.sweep_up),  1);
        chk("reset door_req",  32'(bus.door_req),  0);
        chk("reset call_err",  32'(bus.call_err),  0);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].cv, int'(vecs[k].cf), int'(vecs[k].cur), vecs[k].door, vecs[k].rdy);
            step();
            chk($sformatf("v%0d tgt_valid", k), 32'(bus.tgt_valid), 32'(vecs[k].tv));
            chk($sformatf("v%0d tgt_floor", k), 32'(bus.tgt_floor), 32'(vecs[k].tf));
            chk($sformatf("v%0d pending",   k), 32'(bus.pending),   32'(vecs[k].pend));
            chk($sformatf("v%0d sweep_up",  k), 32'(bus.sweep_up),  32'(vecs[k].sw));
            chk($sformatf("v%0d door_req",  k), 32'(bus.door_req),  32'(vecs[k].dr));
            chk($sformatf("v%0d call_err",  k), 32'(bus.call_err),  32'(vecs[k].ce));
        end

        // Asynchronous reset while a target is being offered, pending {1,8}
        drive(1'b1, 8, 0, 1'b0, 1'b0);
        step();
        chk("pre-rst pending", 32'(bus.pending), 'h100);
        drive(1'b1, 1, 0, 1'b0, 1'b0);
        step();
        chk("pre-rst tgt_valid", 32'(bus.tgt_valid), 1);
        chk("pre-rst tgt_floor", 32'(bus.tgt_floor), 8);
        chk("pre-rst pending2",  32'(bus.pending),   'h102);
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst tgt_valid", 32'(bus.tgt_valid), 0);
        chk("async rst pending",   32'(bus.pending),   0);
        chk("async rst sweep_up",  32'(bus.sweep_up),  1);
        chk("async rst tgt_floor", 32'(bus.tgt_floor), 0);
        step();
        rst = 1'b0;
        drive(1'b1, 5, 0, 1'b0, 1'b0);
        step();
        chk("post-rst pending",   32'(bus.pending),   'h020);
        chk("post-rst tgt_valid0", 32'(bus.tgt_valid), 0);
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        step();
        chk("post-rst tgt_valid", 32'(bus.tgt_valid), 1);
        chk("post-rst tgt_floor", 32'(bus.tgt_floor), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
